set_seq_ctrl: RTL

- Parametrised successor to the SET controller; sequences candidate scanning for the SET datapath (buffer, coordinate generator, accumulator).
- Generalises the fixed 16-cycle scan to N_CAND candidates, multiple passes and a pipeline drain phase.
- Replaces the one-cycle result strobe with a valid/ready hold.
- Sits between the top-level input handshake and the datapath enables.

---
 rtl/set_pkg.sv | 20 ++
 rtl/set_tc_counter.sv | 32 +++
 rtl/set_seq_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// Shared types for the SET sequencing controller: FSM state encoding and the
// index-width helper used to size the candidate/pass/drain counters.
package set_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/set_tc_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag.
// Clear has priority over enable; the caller stops enabling at terminal count.
module set_tc_counter #(
    parameter int WIDTH = 1,
    parameter int TC    = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TC);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= cnt_reg + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_reg;
    assign tc_o  = (cnt_reg == TC_VAL);

endmodule

// File: rtl/set_seq_ctrl.sv
// SET scan sequencer: LOAD / SCAN / DRAIN per pass, NUM_PASS passes per job,
// result held with valid/ready. Define SET_SEQ_CTRL_ABORT_EN to add abort_i.
module set_seq_ctrl
    import set_pkg::*;
#(
    parameter int N_CAND   = 16,
    parameter int PIPE_LAT = 0,
    parameter int NUM_PASS = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic                           ready_i,
`ifdef SET_SEQ_CTRL_ABORT_EN
    input  logic                           abort_i,
`endif
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           buffer_en_o,
    output logic                           coord_en_o,
    output logic                           acc_clear_o,
    output logic                           acc_en_o,
    output logic                           clear_o,
    output logic [idx_width(N_CAND)-1:0]   cand_idx_o,
    output logic [idx_width(NUM_PASS)-1:0] pass_o
);

    localparam int CAND_W = idx_width(N_CAND);
    localparam int PASS_W = idx_width(NUM_PASS);

    state_t state_reg;
    state_t state_next;

    logic cand_tc;
    logic drain_tc;
    logic pass_tc;
    logic abort_w;
    logic accept_w;
    logic start_w;
    logic end_of_pass_w;
    logic cand_clr;
    logic cand_en;
    logic pass_clr;
    logic pass_en;

`ifdef SET_SEQ_CTRL_ABORT_EN
    assign abort_w = abort_i && (state_reg != ST_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    assign start_w       = (state_reg == ST_IDLE) && en_i;
    assign accept_w      = (state_reg == ST_DONE) && ready_i && !abort_w;
    assign end_of_pass_w = ((state_reg == ST_SCAN) && cand_tc && (PIPE_LAT == 0))
                         || ((state_reg == ST_DRAIN) && drain_tc);

    // Candidate index reads 0 in every LOAD and holds N_CAND-1 through DRAIN/DONE.
    assign cand_clr = start_w || (end_of_pass_w && !pass_tc) || accept_w || abort_w;
    assign cand_en  = (state_reg == ST_SCAN) && !cand_tc;
    assign pass_clr = accept_w || abort_w;
    assign pass_en  = end_of_pass_w && !pass_tc;

    set_tc_counter #(
        .WIDTH (CAND_W),
        .TC    (N_CAND - 1)
    ) u_cand_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cand_clr),
        .en_i   (cand_en),
        .cnt_o  (cand_idx_o),
        .tc_o   (cand_tc)
    );

    set_tc_counter #(
        .WIDTH (PASS_W),
        .TC    (NUM_PASS - 1)
    ) u_pass_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (pass_clr),
        .en_i   (pass_en),
        .cnt_o  (pass_o),
        .tc_o   (pass_tc)
    );

    generate
        if (PIPE_LAT > 0) begin : g_drain
            logic [idx_width(PIPE_LAT)-1:0] drain_cnt_unused;
            logic                           drain_clr;
            logic                           drain_en;

            // Held at zero outside DRAIN so every drain phase starts fresh.
            assign drain_clr = (state_reg != ST_DRAIN) || abort_w;
            assign drain_en  = (state_reg == ST_DRAIN) && !drain_tc;

            set_tc_counter #(
                .WIDTH (idx_width(PIPE_LAT)),
                .TC    (PIPE_LAT - 1)
            ) u_drain_cnt (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .clr_i  (drain_clr),
                .en_i   (drain_en),
                .cnt_o  (drain_cnt_unused),
                .tc_o   (drain_tc)
            );
        end else begin : g_no_drain
            assign drain_tc = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        valid_o     = 1'b0;
        busy_o      = (state_reg != ST_IDLE);
        buffer_en_o = 1'b0;
        coord_en_o  = 1'b0;
        acc_clear_o = 1'b0;
        acc_en_o    = 1'b0;
        clear_o     = accept_w || abort_w;

        case (state_reg)
            ST_IDLE: begin
                // Gated by reset so every output reads 0 while rst_ni is low.
                buffer_en_o = en_i && rst_ni;
                if (en_i) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                coord_en_o  = 1'b1;
                acc_clear_o = (pass_o == '0);
                state_next  = ST_SCAN;
            end
            ST_SCAN: begin
                acc_en_o = 1'b1;
                if (cand_tc) begin
                    if (PIPE_LAT > 0) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = pass_tc ? ST_DONE : ST_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                acc_en_o = 1'b1;
                if (drain_tc) begin
                    state_next = pass_tc ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                valid_o = !abort_w;
                if (ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort_w) begin
            state_next = ST_IDLE;
        end
    end

endmodule
